// File: rtl/sampler_pkg.sv
// sampler_pkg
//   Definitions shared between the segment selector and the sampler that
//   consumes its selections: segment-type codes, the selector FSM state
//   encoding, the LFSR reset value and a weight clamp helper.
package sampler_pkg;

   // Segment type codes carried on in_seg_type / out_type
   localparam logic [1:0] EXPDOWN = 2'd1;
   localparam logic [1:0] EXPUP   = 2'd2;
   localparam logic [1:0] UNIFORM = 2'd3;

   // LFSR value after reset, also used when a zero value would be loaded
   localparam logic [15:0] LFSR_RESET = 16'hACE1;

   // Selector FSM. ST_IDLE doubles as the segment load state.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCALE  = 2'd1,
      ST_SEARCH = 2'd2,
      ST_OUTPUT = 2'd3
   } sel_state_t;

   // Signed 8-bit weight clamped at zero: negative weights count as 0.
   function automatic logic [7:0] clamp_weight(input logic [7:0] w);
      return w[7] ? 8'd0 : w;
   endfunction

endpackage

// File: rtl/selector_lfsr.sv
// selector_lfsr
//   16-bit Fibonacci LFSR, shifting left with feedback
//   r[15]^r[13]^r[12]^r[10] into bit 0. Advances every cycle; a seed load
//   takes priority over the advance and loads {seed, ~seed}. A zero load
//   value is replaced by LFSR_RESET so the register can never lock up.
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-high reset (value <= LFSR_RESET)
//   seed_load  in   load {seed, ~seed} this cycle
//   seed       in   seed byte
//   value      out  current LFSR state
module selector_lfsr
   import sampler_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        seed_load,
   input  logic [7:0]  seed,
   output logic [15:0] value
);

   logic [15:0] load_val;
   logic [15:0] next_val;

   always_comb begin
      load_val = {seed, ~seed};
      next_val = {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= LFSR_RESET;
      end else if (seed_load) begin
         value <= (load_val == 16'd0) ? LFSR_RESET : load_val;
      end else begin
         value <= next_val;
      end
   end

endmodule

// File: rtl/segment_selector.sv
// segment_selector
//   Buffers the weighted segments of one variable, draws a point in
//   [0, total weight) from a scaled LFSR value and emits the segment whose
//   cumulative-weight interval contains that point (roulette-wheel pick).
//
//   Handshakes (both sides): a beat/selection transfers on a rising clock
//   edge where valid and ready are both high. The producer holds its data
//   stable while valid is high and ready is low; ready does not depend on
//   valid.
//
//   Build option: SEGMENT_SELECTOR_BINARY_SEARCH_EN selects a binary search
//   of fixed $clog2(MAX_SEGMENTS) cycles instead of the default linear scan
//   (one index per cycle). Both return the same index.
//
// Parameters
//   WIDTH         signed width of from/to bounds
//   MAX_SEGMENTS  buffer depth, power of two >= 2
// Ports
//   in_clock, in_reset            clock, asynchronous active-high reset
//   in_seed_load, in_seed         reseed the LFSR with {seed, ~seed}
//   in_seg_valid / out_seg_ready  segment beat handshake
//   in_seg_from, in_seg_to        segment bounds (signed)
//   in_seg_type, in_seg_weight    segment type, signed weight (<=0 is 0)
//   in_seg_last                   final segment of the variable
//   out_valid / in_ready          selection handshake
//   out_from, out_to, out_type    selected segment
//   out_weight                    selected weight as received
//   out_index                     selected buffer index
//   out_zero_weight               total weight was 0, index 0 forced
//   dbg_state                     current FSM state
module segment_selector
   import sampler_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int MAX_SEGMENTS = 8
) (
   input  logic                             in_clock,
   input  logic                             in_reset,
   input  logic                             in_seed_load,
   input  logic [7:0]                       in_seed,
   input  logic                             in_seg_valid,
   output logic                             out_seg_ready,
   input  logic signed [WIDTH-1:0]          in_seg_from,
   input  logic signed [WIDTH-1:0]          in_seg_to,
   input  logic [1:0]                       in_seg_type,
   input  logic [7:0]                       in_seg_weight,
   input  logic                             in_seg_last,
   output logic                             out_valid,
   input  logic                             in_ready,
   output logic signed [WIDTH-1:0]          out_from,
   output logic signed [WIDTH-1:0]          out_to,
   output logic [1:0]                       out_type,
   output logic [7:0]                       out_weight,
   output logic [$clog2(MAX_SEGMENTS)-1:0]  out_index,
   output logic                             out_zero_weight,
   output sel_state_t                       dbg_state
);

   localparam int IDX_W     = $clog2(MAX_SEGMENTS);
   localparam int CNT_W     = IDX_W + 1;
   localparam int ACC_WIDTH = 8 + IDX_W;

   sel_state_t state, state_nx;

   logic [15:0]          lfsr_value;
   logic [CNT_W-1:0]     count;
   logic [ACC_WIDTH-1:0] total;
   logic [ACC_WIDTH-1:0] target;
   logic [ACC_WIDTH-1:0] cum_next;

   logic signed [WIDTH-1:0] seg_from   [MAX_SEGMENTS];
   logic signed [WIDTH-1:0] seg_to     [MAX_SEGMENTS];
   logic [1:0]              seg_type   [MAX_SEGMENTS];
   logic [7:0]              seg_weight [MAX_SEGMENTS];
   logic [ACC_WIDTH-1:0]    cum        [MAX_SEGMENTS];

   logic             beat_fire;
   logic             load_done;
   logic             search_done;
   logic             search_zero;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] last_idx;
   logic [IDX_W-1:0] search_idx;

   selector_lfsr u_lfsr (
      .clk       (in_clock),
      .rst       (in_reset),
      .seed_load (in_seed_load),
      .seed      (in_seed),
      .value     (lfsr_value)
   );

   always_comb begin
      beat_fire   = in_seg_valid & out_seg_ready;
      // A full buffer ends the list even without in_seg_last
      load_done   = in_seg_last | (count == CNT_W'(MAX_SEGMENTS - 1));
      wr_idx      = count[IDX_W-1:0];
      last_idx    = IDX_W'(count - CNT_W'(1));
      cum_next    = total + ACC_WIDTH'(clamp_weight(in_seg_weight));
      search_zero = (total == '0);
   end

   // ------------------------------------------------------------------
   // Search engine: finds the first index whose cumulative weight exceeds
   // the target. cum[] is non-decreasing and cum[count-1] = total > target,
   // so the answer always lies in [0, count-1].
   // ------------------------------------------------------------------
`ifdef SEGMENT_SELECTOR_BINARY_SEARCH_EN
   logic [IDX_W-1:0] lo, hi, mid, lo_nx, hi_nx;
   logic [CNT_W-1:0] step;

   always_comb begin
      mid   = IDX_W'(({1'b0, lo} + {1'b0, hi}) >> 1);
      lo_nx = lo;
      hi_nx = hi;
      if (cum[mid] > target) begin
         hi_nx = mid;
      end else if (mid < hi) begin
         lo_nx = mid + IDX_W'(1);
      end
      // The interval halves each step, so IDX_W steps always converge;
      // running the full count keeps latency independent of the result.
      search_done = (step == CNT_W'(IDX_W - 1));
      search_idx  = search_zero ? '0 : hi_nx;
   end

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         lo   <= '0;
         hi   <= '0;
         step <= '0;
      end else if (state == ST_SCALE) begin
         lo   <= '0;
         hi   <= last_idx;
         step <= '0;
      end else if (state == ST_SEARCH) begin
         lo   <= lo_nx;
         hi   <= hi_nx;
         step <= step + CNT_W'(1);
      end
   end
`else
   logic [IDX_W-1:0] scan_idx;

   always_comb begin
      // The last loaded slot is always a hit; testing it explicitly keeps
      // the scan from ever walking past the loaded entries.
      search_done = search_zero | (cum[scan_idx] > target) | (scan_idx == last_idx);
      search_idx  = search_zero ? '0 : scan_idx;
   end

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         scan_idx <= '0;
      end else if (state == ST_SCALE) begin
         scan_idx <= '0;
      end else if ((state == ST_SEARCH) && !search_done) begin
         scan_idx <= scan_idx + IDX_W'(1);
      end
   end
`endif

   // ------------------------------------------------------------------
   // FSM: state register / next state / outputs
   // ------------------------------------------------------------------
   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (beat_fire && load_done) state_nx = ST_SCALE;
         ST_SCALE:  state_nx = ST_SEARCH;
         ST_SEARCH: if (search_done) state_nx = ST_OUTPUT;
         ST_OUTPUT: if (in_ready) state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      out_seg_ready = (state == ST_IDLE);
      out_valid     = (state == ST_OUTPUT);
      dbg_state     = state;
   end

   // ------------------------------------------------------------------
   // Segment buffer (no reset: entries beyond count are never read)
   // ------------------------------------------------------------------
   always_ff @(posedge in_clock) begin
      if (beat_fire) begin
         seg_from[wr_idx]   <= in_seg_from;
         seg_to[wr_idx]     <= in_seg_to;
         seg_type[wr_idx]   <= in_seg_type;
         seg_weight[wr_idx] <= in_seg_weight;
         cum[wr_idx]        <= cum_next;
      end
   end

   // Load accounting and draw scaling
   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         count  <= '0;
         total  <= '0;
         target <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (beat_fire) begin
                  count <= count + CNT_W'(1);
                  total <= cum_next;
               end
            end
            ST_SCALE: begin
               // lfsr/2^16 < 1, so the scaled draw is strictly below total
               target <= ACC_WIDTH'(({{ACC_WIDTH{1'b0}}, lfsr_value} *
                                     {16'd0, total}) >> 16);
            end
            ST_OUTPUT: begin
               if (in_ready) begin
                  count <= '0;
                  total <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Selection registers: captured on leaving SEARCH, held afterwards
   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         out_from        <= '0;
         out_to          <= '0;
         out_type        <= '0;
         out_weight      <= '0;
         out_index       <= '0;
         out_zero_weight <= 1'b0;
      end else if ((state == ST_SEARCH) && search_done) begin
         out_from        <= seg_from[search_idx];
         out_to          <= seg_to[search_idx];
         out_type        <= seg_type[search_idx];
         out_weight      <= seg_weight[search_idx];
         out_index       <= search_idx;
         out_zero_weight <= search_zero;
      end
   end

endmodule

// File: tb/tb_segment_selector.sv
// tb_segment_selector
//   Directed bench for segment_selector (WIDTH=8, MAX_SEGMENTS=8): a table
//   of segment lists with expected selections, random-draw sequences checked
//   against a roulette-wheel reference, and hand-written sequences for
//   buffer overflow, output stall and mid-load reset.
module tb_segment_selector;
   import sampler_pkg::*;

   localparam int WIDTH   = 8;
   localparam int MAX_SEG = 8;
   localparam int IDX_W   = 3;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   logic                    in_seed_load;
   logic [7:0]              in_seed;
   logic                    in_seg_valid;
   logic                    out_seg_ready;
   logic signed [WIDTH-1:0] in_seg_from;
   logic signed [WIDTH-1:0] in_seg_to;
   logic [1:0]              in_seg_type;
   logic [7:0]              in_seg_weight;
   logic                    in_seg_last;
   logic                    out_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] out_from;
   logic signed [WIDTH-1:0] out_to;
   logic [1:0]              out_type;
   logic [7:0]              out_weight;
   logic [IDX_W-1:0]        out_index;
   logic                    out_zero_weight;
   sel_state_t              dbg_state;

   segment_selector #(.WIDTH(WIDTH), .MAX_SEGMENTS(MAX_SEG)) dut (
      .in_clock        (clk),
      .in_reset        (rst),
      .in_seed_load    (in_seed_load),
      .in_seed         (in_seed),
      .in_seg_valid    (in_seg_valid),
      .out_seg_ready   (out_seg_ready),
      .in_seg_from     (in_seg_from),
      .in_seg_to       (in_seg_to),
      .in_seg_type     (in_seg_type),
      .in_seg_weight   (in_seg_weight),
      .in_seg_last     (in_seg_last),
      .out_valid       (out_valid),
      .in_ready        (in_ready),
      .out_from        (out_from),
      .out_to          (out_to),
      .out_type        (out_type),
      .out_weight      (out_weight),
      .out_index       (out_index),
      .out_zero_weight (out_zero_weight),
      .dbg_state       (dbg_state)
   );

   // ---------------- reference LFSR ----------------
   logic [15:0] m_lfsr;

   always @(posedge clk or posedge rst) begin
      if (rst)               m_lfsr <= 16'hACE1;
      else if (in_seed_load) m_lfsr <= {in_seed, ~in_seed};
      else                   m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   // ---------------- scoreboard ----------------
   int total_cnt = 0;
   int bad_cnt   = 0;

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act != exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      total_cnt++;
      if (act < lo || act > hi) begin
         bad_cnt++;
         $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Current segment list being driven
   logic signed [7:0] tf  [MAX_SEG];
   logic signed [7:0] tt  [MAX_SEG];
   logic [1:0]        tty [MAX_SEG];
   logic [7:0]        tw  [MAX_SEG];

   function automatic void fill_default();
      for (int i = 0; i < MAX_SEG; i++) begin
         tf[i]  = 8'(i * 7 - 20);
         tt[i]  = 8'(i * 9 + 3);
         tty[i] = 2'(i % 3 + 1);
         tw[i]  = 8'd0;
      end
   endfunction

   // Roulette-wheel reference: target = (r*total)>>16, first cum > target
   function automatic int model_idx(input logic [15:0] r, input int n, output bit zero);
      longint unsigned tot;
      longint unsigned tgt;
      longint unsigned cum [MAX_SEG];
      tot = 0;
      for (int i = 0; i < n; i++) begin
         if (!tw[i][7]) tot += longint'(tw[i]);
         cum[i] = tot;
      end
      zero = (tot == 0);
      if (zero) return 0;
      tgt = (longint'(r) * tot) >> 16;
      for (int i = 0; i < n; i++) begin
         if (cum[i] > tgt) return i;
      end
      return n - 1;
   endfunction

   // ---------------- drivers ----------------
   task automatic send_beat(input logic signed [7:0] f, input logic signed [7:0] t,
                            input logic [1:0] ty, input logic [7:0] w,
                            input logic last, output bit ok);
      logic rdy;
      in_seg_valid  = 1'b1;
      in_seg_from   = f;
      in_seg_to     = t;
      in_seg_type   = ty;
      in_seg_weight = w;
      in_seg_last   = last;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         rdy = out_seg_ready;
         @(posedge clk);
         #1;
         if (rdy) ok = 1'b1;
      end
      in_seg_valid = 1'b0;
      in_seg_last  = 1'b0;
      if (!ok) check("beat_accept_timeout", 0, 1);
   endtask

   task automatic seed_load(input logic [7:0] s);
      in_seed_load = 1'b1;
      in_seed      = s;
      @(posedge clk);
      #1;
      in_seed_load = 1'b0;
   endtask

   // Called #1 after the edge that accepted the final beat
   task automatic finish_list(input int e_idx, input bit e_zero, input int hold,
                              output int got_idx);
      int lat;
      int lat_exp;
      bit saw_ready;
      got_idx   = -1;
      lat       = 1;
      saw_ready = out_seg_ready;
`ifdef SEGMENT_SELECTOR_BINARY_SEARCH_EN
      lat_exp = 2 + IDX_W;
`else
      lat_exp = 3 + e_idx;
`endif
      while (!out_valid && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
         if (out_seg_ready) saw_ready = 1'b1;
      end
      if (!out_valid) begin
         check("out_valid_timeout", 0, 1);
         in_seg_valid = 1'b0;
         return;
      end
      got_idx = int'(out_index);
      check("latency", lat, lat_exp);
      check("index", int'(out_index), e_idx);
      check("zero_weight", int'(out_zero_weight), int'(e_zero));
      check("from", int'(out_from), int'(tf[e_idx]));
      check("to", int'(out_to), int'(tt[e_idx]));
      check("type", int'(out_type), int'(tty[e_idx]));
      check("weight", int'(out_weight), int'(tw[e_idx]));
      check("state_output", int'(dbg_state), int'(ST_OUTPUT));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check("stall_valid", int'(out_valid), 1);
         check("stall_index", int'(out_index), e_idx);
         check("stall_from", int'(out_from), int'(tf[e_idx]));
         check("stall_weight", int'(out_weight), int'(tw[e_idx]));
         if (out_seg_ready) saw_ready = 1'b1;
      end
      check("ready_low_busy", int'(saw_ready), 0);
      in_seg_valid = 1'b0;
      in_ready     = 1'b1;
      @(posedge clk);
      #1;
      in_ready = 1'b0;
      check("valid_drop", int'(out_valid), 0);
      check("ready_back", int'(out_seg_ready), 1);
      check("index_retained", int'(out_index), e_idx);
   endtask

   task automatic run_list(input int n, input int exp_idx, input bit exp_zero,
                           output int got_idx);
      bit ok;
      bit m_zero;
      int m_idx;
      int e_idx;
      bit e_zero;
      got_idx = -1;
      for (int i = 0; i < n; i++) begin
         send_beat(tf[i], tt[i], tty[i], tw[i], (i == n - 1), ok);
         if (!ok) return;
      end
      m_idx = model_idx(m_lfsr, n, m_zero);
      if (exp_idx < 0) begin
         e_idx  = m_idx;
         e_zero = m_zero;
      end else begin
         e_idx  = exp_idx;
         e_zero = exp_zero;
      end
      finish_list(e_idx, e_zero, 0, got_idx);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int                n;
      logic [7:0]        w0, w1, w2;
      logic signed [7:0] f0, t0;
      logic [1:0]        ty0;
      int                exp_idx;   // -1: use the reference draw
      bit                exp_zero;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #20_000_000;
      $display("FAIL watchdog: got timeout, want test end");
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      int hist [3];
      bit ok;
      bit m_zero;
      int m_idx;

      vecs[0] = '{1, 8'd5,   8'd0,   8'd0,   8'hFB, 8'h14, 2'd3, 0, 1'b0};
      vecs[1] = '{3, 8'd0,   8'd0,   8'd7,   8'h10, 8'h20, 2'd1, 2, 1'b0};
      vecs[2] = '{3, 8'd0,   8'd0,   8'd0,   8'hF0, 8'h05, 2'd2, 0, 1'b1};
      vecs[3] = '{2, 8'hFD,  8'd9,   8'd0,   8'h00, 8'h7F, 2'd1, 1, 1'b0};
      vecs[4] = '{3, 8'd127, 8'd0,   8'd0,   8'h80, 8'h7F, 2'd3, 0, 1'b0};
      vecs[5] = '{3, 8'd10,  8'd20,  8'd30,  8'hE0, 8'h30, 2'd2, -1, 1'b0};
      vecs[6] = '{2, 8'h80,  8'd0,   8'd0,   8'h01, 8'h02, 2'd1, 0, 1'b1};
      vecs[7] = '{3, 8'd0,   8'd127, 8'hFF,  8'h11, 8'h22, 2'd2, 1, 1'b0};

      in_seed_load  = 1'b0;
      in_seed       = 8'd0;
      in_seg_valid  = 1'b0;
      in_seg_from   = '0;
      in_seg_to     = '0;
      in_seg_type   = '0;
      in_seg_weight = '0;
      in_seg_last   = 1'b0;
      in_ready      = 1'b0;
      rst           = 1'b1;
      fill_default();

      // ---- reset state ----
      repeat (2) @(posedge clk);
      #1;
      check("rst_seg_ready", int'(out_seg_ready), 1);
      check("rst_valid", int'(out_valid), 0);
      check("rst_index", int'(out_index), 0);
      check("rst_from", int'(out_from), 0);
      check("rst_to", int'(out_to), 0);
      check("rst_type", int'(out_type), 0);
      check("rst_weight", int'(out_weight), 0);
      check("rst_zero", int'(out_zero_weight), 0);
      check("rst_state", int'(dbg_state), int'(ST_IDLE));
      rst = 1'b0;
      @(posedge clk);
      #1;

      // ---- table vectors ----
      foreach (vecs[v]) begin
         fill_default();
         tw[0]  = vecs[v].w0;
         tw[1]  = vecs[v].w1;
         tw[2]  = vecs[v].w2;
         tf[0]  = vecs[v].f0;
         tt[0]  = vecs[v].t0;
         tty[0] = vecs[v].ty0;
         run_list(vecs[v].n, vecs[v].exp_idx, vecs[v].exp_zero, got);
      end

      // ---- weights 0,0,7: always index 2 ----
      fill_default();
      tw[2] = 8'd7;
      for (int d = 0; d < 200; d++) run_list(3, 2, 1'b0, got);

      // ---- weights 10,20,30 after reseed: reference draws + histogram ----
      seed_load(8'h5A);
      fill_default();
      tw[0] = 8'd10;
      tw[1] = 8'd20;
      tw[2] = 8'd30;
      hist = '{0, 0, 0};
      for (int d = 0; d < 1000; d++) begin
         run_list(3, -1, 1'b0, got);
         if (got >= 0 && got < 3) hist[got]++;
      end
      check_range("hist_idx0", hist[0], 167 - 50, 167 + 50);
      check_range("hist_idx1", hist[1], 333 - 50, 333 + 50);
      check_range("hist_idx2", hist[2], 500 - 50, 500 + 50);

      // ---- 9 beats without last: buffer fills at 8, stalled output ----
      fill_default();
      for (int i = 0; i < MAX_SEG; i++) tw[i] = 8'(i + 1);
      ok = 1'b1;
      for (int i = 0; i < MAX_SEG && ok; i++) begin
         send_beat(tf[i], tt[i], tty[i], tw[i], 1'b0, ok);
      end
      m_idx = model_idx(m_lfsr, MAX_SEG, m_zero);
      // ninth beat offered while the selector is busy
      in_seg_valid  = 1'b1;
      in_seg_from   = 8'h55;
      in_seg_to     = 8'h66;
      in_seg_type   = UNIFORM;
      in_seg_weight = 8'd50;
      in_seg_last   = 1'b0;
      finish_list(m_idx, m_zero, 10, got);
      // the count must have been cleared: one segment selects index 0
      fill_default();
      tw[0] = 8'd3;
      run_list(1, 0, 1'b0, got);

      // ---- reset after 2 of 4 beats ----
      fill_default();
      tw[0] = 8'd50;
      tw[1] = 8'd50;
      send_beat(tf[0], tt[0], tty[0], tw[0], 1'b0, ok);
      send_beat(tf[1], tt[1], tty[1], tw[1], 1'b0, ok);
      rst = 1'b1;
      #2;
      check("mid_rst_seg_ready", int'(out_seg_ready), 1);
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_index", int'(out_index), 0);
      check("mid_rst_from", int'(out_from), 0);
      check("mid_rst_weight", int'(out_weight), 0);
      check("mid_rst_state", int'(dbg_state), int'(ST_IDLE));
      rst = 1'b0;
      @(posedge clk);
      #1;
      fill_default();
      tw[1] = 8'd9;
      run_list(2, 1, 1'b0, got);
      fill_default();
      tw[0] = 8'd10;
      tw[1] = 8'd20;
      tw[2] = 8'd30;
      for (int d = 0; d < 20; d++) run_list(3, -1, 1'b0, got);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
